// File: rtl/riscv_regfile_sb.sv
// Register file with per-register outstanding-producer scoreboard; define RISCV_REGFILE_BYPASS_EN for same-cycle write bypass.
// Latency: data and lock state visible one cycle after the request (data same cycle with bypass); no backpressure, requests always accepted.
module riscv_regfile_sb #(
   parameter int PORTS = 2,
   parameter int XLEN  = 32,
   parameter int NREGS = 32,
   parameter int CNT_W = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic [PORTS-1:0]       register_lock_en,
   input  logic [PORTS*AW-1:0]    register_lock,
   input  logic [PORTS-1:0]       register_write_en,
   input  logic [PORTS*AW-1:0]    register_write,
   input  logic [PORTS*XLEN-1:0]  register_write_data,
   input  logic                   flush,
   output logic [NREGS*XLEN-1:0]  register,
   output logic [NREGS-1:0]       register_locked,
   output logic                   sb_error
);

   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic [XLEN-1:0]  data_q [NREGS];
   logic [CNT_W-1:0] cnt_q  [NREGS];
   logic [CNT_W-1:0] cnt_d  [NREGS];
   logic             wr_hit [NREGS];
   logic [XLEN-1:0]  wr_val [NREGS];
   logic             err_set;
   logic             err_q;

   // Register 0 is never touched by the loops below, so it stays at its reset value.
   always_comb begin
      int lk;
      int wc;
      int sum;
      err_set = 1'b0;
      for (int r = 0; r < NREGS; r++) begin
         cnt_d[r]  = cnt_q[r];
         wr_hit[r] = 1'b0;
         wr_val[r] = '0;
      end
      for (int r = 1; r < NREGS; r++) begin
         lk = 0;
         wc = 0;
         for (int p = 0; p < PORTS; p++) begin
            if (register_lock_en[p] && int'(register_lock[p*AW +: AW]) == r)
               lk = lk + 1;
            if (register_write_en[p] && int'(register_write[p*AW +: AW]) == r) begin
               wc        = wc + 1;
               wr_hit[r] = 1'b1;
               wr_val[r] = register_write_data[p*XLEN +: XLEN];
            end
         end
         sum = int'(cnt_q[r]) + lk - wc;
         if (flush) begin
            cnt_d[r] = '0;
         end else if (sum > CNT_MAX) begin
            cnt_d[r] = CNT_W'(CNT_MAX);
            err_set  = 1'b1;
         end else if (sum < 0) begin
            cnt_d[r] = '0;
            err_set  = 1'b1;
         end else begin
            cnt_d[r] = CNT_W'(sum);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) begin
            data_q[r] <= '0;
            cnt_q[r]  <= '0;
         end
         err_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            if (wr_hit[r])
               data_q[r] <= wr_val[r];
            cnt_q[r] <= cnt_d[r];
         end
         if (err_set)
            err_q <= 1'b1;
      end
   end

   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
`ifdef RISCV_REGFILE_BYPASS_EN
         register[r*XLEN +: XLEN] = wr_hit[r] ? wr_val[r] : data_q[r];
`else
         register[r*XLEN +: XLEN] = data_q[r];
`endif
         register_locked[r] = (cnt_q[r] != '0);
      end
   end

   assign sb_error = err_q;

endmodule
